mips_reg_file: RTL and testbench
================================

Name: mips_reg_file

Overview:
Parametrised general-purpose register file for the MIPS core, succeeding the single fixed 32-bit register. Provides:
- 2 asynchronous read ports (rs, rt) and 1 synchronous write port with per-byte write enables, so LWL/LWR partial writes can be done.
- Separate HI/LO special registers for MULT/DIV/MTHI/MTLO.
- Optional same-cycle write-to-read bypass.
- Continuous debug tap of $v0 for the testbench.
Sits between decode (read addresses) and write-back (write port) in the datapath.

Parameters:
DATA_WIDTH, 32, register width in bits; must be a multiple of 8.
ADDR_WIDTH, 5, register address width; NUM_REGS = 2**ADDR_WIDTH (localparam).
BYPASS, 1, 1 = read ports return the same-cycle write data merged by byte enables; 0 = read ports return stored contents only.
DEBUG_INDEX, 2, register index driven onto dbg_data ($v0).

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
rs_addr  input  ADDR_WIDTH  read port A address
rt_addr  input  ADDR_WIDTH  read port B address
rs_data  output  DATA_WIDTH  read port A data
rt_data  output  DATA_WIDTH  read port B data
wr_en  input  1  GPR write request
wr_addr  input  ADDR_WIDTH  GPR write address
wr_byte_en  input  DATA_WIDTH/8  per-byte write mask; bit i covers bits [8i+7:8i]
wr_data  input  DATA_WIDTH  GPR write data
hilo_we  input  2  bit1 = write HI, bit0 = write LO
hi_wdata  input  DATA_WIDTH  HI write data
lo_wdata  input  DATA_WIDTH  LO write data
hi_data  output  DATA_WIDTH  HI contents
lo_data  output  DATA_WIDTH  LO contents
dbg_data  output  DATA_WIDTH  stored contents of register DEBUG_INDEX

Behaviour:
- Reset (clk = rising edge, reset = 1):
  - All NUM_REGS GPRs, HI and LO cleared to 0.
  - Reset has priority over every write in the same cycle.
  - Reset mid-sequence discards any pending write in that cycle.
- GPR write on a rising edge with reset = 0, wr_en = 1 and wr_addr != 0:
  - Each byte i with wr_byte_en[i] = 1 takes wr_data byte i.
  - All other bytes keep their old value.
  - wr_byte_en = 0 means no change.
- Register 0 is hardwired to zero:
  - Writes to it are discarded.
  - Reads of it return 0 regardless of BYPASS.
- Reads are combinational, with zero-cycle latency from address to data.
- Bypass, when BYPASS = 1, wr_en = 1, wr_addr = read address and the address is non-zero:
  - The read port returns the merge: bytes with wr_byte_en set come from wr_data, the rest from the stored register.
  - Applies independently to rs and rt; both may hit simultaneously.
  - Bypass is suppressed while reset = 1; the read returns stored contents.
- When BYPASS = 0, reads always return stored contents, so write data is visible from the cycle after the edge.
- HI/LO:
  - Each of hi_wdata / lo_wdata is written in full when its hilo_we bit is set and reset = 0. Both may be written in the same cycle.
  - With BYPASS = 1, hi_data / lo_data forward the same-cycle write data; otherwise they show stored values.
  - HI/LO writes are independent of wr_en; GPR and HI/LO writes may coincide.
- dbg_data always shows stored contents, never bypassed, so the testbench sees only committed state.
- Out-of-range addresses cannot occur because NUM_REGS = 2**ADDR_WIDTH. No X propagation from uninitialised storage after the first reset.

Decomposition:
- Shared package mips_pkg: DATA_WIDTH/ADDR_WIDTH defaults, the REG_ZERO = 0 and REG_V0 = 2 constants, and a byte-merge function (old, new, mask) → merged. The write path and both bypass paths use that function.
- HI/LO is a natural sub-module hilo_reg: 2 registers, 2-bit enable, optional bypass. It replaces the former single-register block.
- The GPR array stays inline.

Test Plan:
- Reset, then read all addresses → every rs_data/rt_data, hi_data, lo_data and dbg_data = 0x00000000.
- Write r2 = 0xDEADBEEF with byte_en = 4'b1111; next cycle rs_addr = 2 → 0xDEADBEEF; dbg_data = 0xDEADBEEF.
- r5 = 0x11223344, then write 0xAABBCCDD with byte_en = 4'b0110 → r5 = 0x11BBCC44.
- Write r0 = 0xFFFFFFFF with BYPASS = 1, rs_addr = 0 in the same cycle → rs_data = 0 in that cycle and after.
- BYPASS = 1:
  - Write r7 = 0x00000055 (full mask) with rs_addr = rt_addr = 7 in the same cycle → both ports = 0x00000055 before the edge.
  - dbg_data is unchanged.
  - With BYPASS = 0, both ports show the old value until the edge.
- hilo_we = 2'b11, hi = 0x1, lo = 0x2, reset = 1 in the same cycle → hi_data = lo_data = 0. Next cycle with reset = 0 → hi_data = 0x1, lo_data = 0x2.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS register file slice.
// Holds the default widths, the architectural register constants and the
// byte-merge helper used by the GPR write path and both GPR bypass paths.
package mips_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 32;
  localparam int unsigned DEF_ADDR_WIDTH  = 5;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_V0   = 2;

  // byte_merge works on the widest supported register; callers widen/narrow
  localparam int unsigned MERGE_MAX_WIDTH = 128;
  localparam int unsigned MERGE_MAX_BYTES = MERGE_MAX_WIDTH / 8;

  // Bytes with mask set come from new_val, the others from old_val.
  function automatic logic [MERGE_MAX_WIDTH-1:0] byte_merge(
    input logic [MERGE_MAX_WIDTH-1:0] old_val,
    input logic [MERGE_MAX_WIDTH-1:0] new_val,
    input logic [MERGE_MAX_BYTES-1:0] mask
  );
    logic [MERGE_MAX_WIDTH-1:0] merged;
    merged = old_val;
    for (int unsigned i = 0; i < MERGE_MAX_BYTES; i++) begin
      if (mask[i]) merged[8*i +: 8] = new_val[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/hilo_reg.sv
// HI/LO special registers for MULT/DIV/MTHI/MTLO.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   we[1:0]             - bit1 writes HI, bit0 writes LO (full-width writes)
//   hi_wdata, lo_wdata  - write data
//   hi_data, lo_data    - contents, or same-cycle write data when BYPASS = 1
module hilo_reg
  import mips_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            we,
  input  logic [DATA_WIDTH-1:0] hi_wdata,
  input  logic [DATA_WIDTH-1:0] lo_wdata,
  output logic [DATA_WIDTH-1:0] hi_data,
  output logic [DATA_WIDTH-1:0] lo_data
);

  logic [DATA_WIDTH-1:0] hi_q;
  logic [DATA_WIDTH-1:0] lo_q;

  // Storage: reset wins over any write in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (we[1]) hi_q <= hi_wdata;
      if (we[0]) lo_q <= lo_wdata;
    end
  end

  // Forwarding is held off during reset since that write will be dropped
  always_comb begin
    hi_data = hi_q;
    lo_data = lo_q;
    if ((BYPASS != 0) && !reset) begin
      if (we[1]) hi_data = hi_wdata;
      if (we[0]) lo_data = lo_wdata;
    end
  end

endmodule

// File: rtl/mips_reg_file.sv
// General-purpose register file for the MIPS core.
// Two combinational read ports (rs, rt), one synchronous write port with
// per-byte enables (LWL/LWR), HI/LO registers, optional same-cycle bypass
// and a debug tap of one stored register.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   rs_addr/rs_data, rt_addr/rt_data - read ports
//   wr_en, wr_addr, wr_byte_en, wr_data - GPR write port
//   hilo_we, hi_wdata, lo_wdata     - HI/LO write port
//   hi_data, lo_data                - HI/LO read
//   dbg_data                        - committed contents of DEBUG_INDEX
module mips_reg_file
  import mips_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned BYPASS      = 1,
  parameter int unsigned DEBUG_INDEX = REG_V0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   rs_addr,
  input  logic [ADDR_WIDTH-1:0]   rt_addr,
  output logic [DATA_WIDTH-1:0]   rs_data,
  output logic [DATA_WIDTH-1:0]   rt_data,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH/8-1:0] wr_byte_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [1:0]              hilo_we,
  input  logic [DATA_WIDTH-1:0]   hi_wdata,
  input  logic [DATA_WIDTH-1:0]   lo_wdata,
  output logic [DATA_WIDTH-1:0]   hi_data,
  output logic [DATA_WIDTH-1:0]   lo_data,
  output logic [DATA_WIDTH-1:0]   dbg_data
);

  localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
  localparam int unsigned NUM_REGS  = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);
  localparam logic [ADDR_WIDTH-1:0] DBG_ADDR  = ADDR_WIDTH'(DEBUG_INDEX);

  generate
    if (((DATA_WIDTH % 8) != 0) || (DATA_WIDTH > MERGE_MAX_WIDTH) ||
        (DEBUG_INDEX >= NUM_REGS)) begin : g_param_check
      $error("mips_reg_file: unsupported DATA_WIDTH or DEBUG_INDEX");
    end
  endgenerate

  // Adapts the package-wide merge helper to this instance's width
  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_val,
    input logic [DATA_WIDTH-1:0] new_val,
    input logic [NUM_BYTES-1:0]  mask
  );
    return DATA_WIDTH'(byte_merge(MERGE_MAX_WIDTH'(old_val),
                                  MERGE_MAX_WIDTH'(new_val),
                                  MERGE_MAX_BYTES'(mask)));
  endfunction

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] wr_merged;

  assign wr_merged = merge_bytes(regs[wr_addr], wr_data, wr_byte_en);

  // GPR array; entry 0 is never written so it stays at its reset value
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != ZERO_ADDR)) begin
      regs[wr_addr] <= wr_merged;
    end
  end

  logic [ADDR_WIDTH-1:0] rd_addr [2];
  logic [DATA_WIDTH-1:0] rd_data [2];

  assign rd_addr[0] = rs_addr;
  assign rd_addr[1] = rt_addr;
  assign rs_data    = rd_data[0];
  assign rt_data    = rd_data[1];

  // Read ports: r0 forced to zero, optional merge with the in-flight write
  generate
    for (genvar p = 0; p < 2; p++) begin : g_rd
      logic [DATA_WIDTH-1:0] stored;
      logic                  hit;

      assign stored = (rd_addr[p] == ZERO_ADDR) ? '0 : regs[rd_addr[p]];
      assign hit    = (BYPASS != 0) && !reset && wr_en &&
                      (wr_addr == rd_addr[p]) && (rd_addr[p] != ZERO_ADDR);
      assign rd_data[p] = hit ? merge_bytes(stored, wr_data, wr_byte_en)
                              : stored;
    end
  endgenerate

  // Debug tap shows committed state only
  assign dbg_data = regs[DBG_ADDR];

  hilo_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .BYPASS     (BYPASS)
  ) u_hilo (
    .clk      (clk),
    .reset    (reset),
    .we       (hilo_we),
    .hi_wdata (hi_wdata),
    .lo_wdata (lo_wdata),
    .hi_data  (hi_data),
    .lo_data  (lo_data)
  );

endmodule

// File: tb/tb_mips_reg_file.sv
// Self-checking bench for mips_reg_file: a BYPASS=1 and a BYPASS=0 instance
// share all inputs; expectations are queued as stimulus is driven and
// compared against the outputs before/after each rising edge.
module tb_mips_reg_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_addr, rt_addr, wr_addr;
  logic        wr_en;
  logic [3:0]  wr_byte_en;
  logic [31:0] wr_data, hi_wdata, lo_wdata;
  logic [1:0]  hilo_we;

  logic [31:0] rs_b, rt_b, hi_b, lo_b, dbg_b;
  logic [31:0] rs_n, rt_n, hi_n, lo_n, dbg_n;

  always #5 clk = ~clk;

  mips_reg_file #(.BYPASS(1)) dut (
    .clk(clk), .reset(reset), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_b), .rt_data(rt_b), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_byte_en(wr_byte_en), .wr_data(wr_data), .hilo_we(hilo_we),
    .hi_wdata(hi_wdata), .lo_wdata(lo_wdata), .hi_data(hi_b),
    .lo_data(lo_b), .dbg_data(dbg_b)
  );

  mips_reg_file #(.BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_n), .rt_data(rt_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_byte_en(wr_byte_en), .wr_data(wr_data), .hilo_we(hilo_we),
    .hi_wdata(hi_wdata), .lo_wdata(lo_wdata), .hi_data(hi_n),
    .lo_data(lo_n), .dbg_data(dbg_n)
  );

  typedef enum int {S_RS, S_RT, S_HI, S_LO, S_DBG,
                    S_RS_N, S_RT_N, S_HI_N, S_LO_N, S_DBG_N} sel_t;
  typedef struct {
    string       tag;
    sel_t        sel;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] m [32];
  logic [31:0] mhi, mlo;

  function automatic logic [31:0] observed(input sel_t s);
    case (s)
      S_RS:    return rs_b;
      S_RT:    return rt_b;
      S_HI:    return hi_b;
      S_LO:    return lo_b;
      S_DBG:   return dbg_b;
      S_RS_N:  return rs_n;
      S_RT_N:  return rt_n;
      S_HI_N:  return hi_n;
      S_LO_N:  return lo_n;
      default: return dbg_n;
    endcase
  endfunction

  function automatic logic [31:0] tb_merge(input logic [31:0] o,
                                           input logic [31:0] n,
                                           input logic [3:0] be);
    logic [31:0] mk;
    for (int b = 0; b < 4; b++) mk[b*8 +: 8] = {8{be[b]}};
    return (o & ~mk) | (n & mk);
  endfunction

  // Expected read value from the model, as seen before the next edge
  function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'h0;
    if (byp && !reset && wr_en && (wr_addr == a))
      return tb_merge(m[a], wr_data, wr_byte_en);
    return m[a];
  endfunction

  task automatic push(input string tag, input sel_t s, input logic [31:0] e);
    exp_t x;
    x.tag = tag; x.sel = s; x.exp = e;
    sb.push_back(x);
  endtask

  task automatic check_all();
    exp_t x;
    logic [31:0] o;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      o = observed(x.sel);
      n_assert++;
      assert (o === x.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", x.tag, o, x.exp);
      end
    end
  endtask

  // Queue model-based expectations for every output of both instances
  task automatic push_model(input string tag);
    push({tag, "_rs"},   S_RS,   exp_read(rs_addr, 1'b1));
    push({tag, "_rt"},   S_RT,   exp_read(rt_addr, 1'b1));
    push({tag, "_rs_n"}, S_RS_N, exp_read(rs_addr, 1'b0));
    push({tag, "_rt_n"}, S_RT_N, exp_read(rt_addr, 1'b0));
    push({tag, "_hi"},   S_HI,   (!reset && hilo_we[1]) ? hi_wdata : mhi);
    push({tag, "_lo"},   S_LO,   (!reset && hilo_we[0]) ? lo_wdata : mlo);
    push({tag, "_hi_n"}, S_HI_N, mhi);
    push({tag, "_lo_n"}, S_LO_N, mlo);
    push({tag, "_dbg"},  S_DBG,  m[2]);
    push({tag, "_dbg_n"}, S_DBG_N, m[2]);
  endtask

  // One clock: model commits what the DUT sees at the edge, inputs change on negedge
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) m[i] = 32'h0;
      mhi = 32'h0; mlo = 32'h0;
    end else begin
      if (wr_en && wr_addr != 5'd0) m[wr_addr] = tb_merge(m[wr_addr], wr_data, wr_byte_en);
      if (hilo_we[1]) mhi = hi_wdata;
      if (hilo_we[0]) mlo = lo_wdata;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_byte_en = '0; wr_data = '0;
    hilo_we = '0; hi_wdata = '0; lo_wdata = '0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m[i] = 32'h0;
    mhi = 32'h0; mlo = 32'h0;
    idle();
    reset = 1'b1; rs_addr = '0; rt_addr = '0;
    @(negedge clk);
    tick();
    reset = 1'b0;

    // Reset state on every address
    for (int a = 0; a < 32; a++) begin
      rs_addr = 5'(a); rt_addr = 5'(31 - a);
      #1;
      push("rst_rs", S_RS, 32'h0);     push("rst_rt", S_RT, 32'h0);
      push("rst_rs_n", S_RS_N, 32'h0); push("rst_rt_n", S_RT_N, 32'h0);
      check_all();
    end
    push("rst_hi", S_HI, 32'h0); push("rst_lo", S_LO, 32'h0);
    push("rst_dbg", S_DBG, 32'h0); push("rst_dbg_n", S_DBG_N, 32'h0);
    check_all();

    // Full write of $v0
    wr_en = 1'b1; wr_addr = 5'd2; wr_byte_en = 4'b1111; wr_data = 32'hDEADBEEF;
    rs_addr = 5'd2; #1;
    push("v0_byp", S_RS, 32'hDEADBEEF); push("v0_nb_old", S_RS_N, 32'h0);
    push("v0_dbg_pre", S_DBG, 32'h0);
    check_all();
    tick(); idle(); #1;
    push("v0_rs", S_RS, 32'hDEADBEEF); push("v0_rs_n", S_RS_N, 32'hDEADBEEF);
    push("v0_dbg", S_DBG, 32'hDEADBEEF); push("v0_dbg_n", S_DBG_N, 32'hDEADBEEF);
    check_all();

    // Partial write: middle two bytes
    wr_en = 1'b1; wr_addr = 5'd5; wr_byte_en = 4'b1111; wr_data = 32'h11223344;
    tick();
    wr_byte_en = 4'b0110; wr_data = 32'hAABBCCDD; rs_addr = 5'd5; rt_addr = 5'd5; #1;
    push("part_byp", S_RS, 32'h11BBCC44); push("part_nb_old", S_RT_N, 32'h11223344);
    check_all();
    tick(); idle(); #1;
    push("part_rs", S_RS, 32'h11BBCC44); push("part_rs_n", S_RS_N, 32'h11BBCC44);
    check_all();

    // Empty byte mask leaves the register alone
    wr_en = 1'b1; wr_addr = 5'd5; wr_byte_en = 4'b0000; wr_data = 32'hFFFFFFFF; #1;
    push("nomask_byp", S_RS, 32'h11BBCC44);
    check_all();
    tick(); idle(); #1;
    push("nomask_rs", S_RS, 32'h11BBCC44);
    check_all();

    // r0 write is discarded, reads stay zero even with bypass
    wr_en = 1'b1; wr_addr = 5'd0; wr_byte_en = 4'b1111; wr_data = 32'hFFFFFFFF;
    rs_addr = 5'd0; rt_addr = 5'd0; #1;
    push("r0_byp_rs", S_RS, 32'h0); push("r0_byp_rt", S_RT, 32'h0);
    push("r0_nb_rs", S_RS_N, 32'h0);
    check_all();
    tick(); idle(); #1;
    push("r0_rs", S_RS, 32'h0); push("r0_rs_n", S_RS_N, 32'h0);
    check_all();

    // Both read ports hit the same in-flight write
    wr_en = 1'b1; wr_addr = 5'd7; wr_byte_en = 4'b1111; wr_data = 32'h00000055;
    rs_addr = 5'd7; rt_addr = 5'd7; #1;
    push("dual_rs", S_RS, 32'h00000055); push("dual_rt", S_RT, 32'h00000055);
    push("dual_rs_n", S_RS_N, 32'h0);    push("dual_rt_n", S_RT_N, 32'h0);
    push("dual_dbg", S_DBG, 32'hDEADBEEF);
    check_all();
    tick(); idle(); #1;
    push("dual_rs_n_post", S_RS_N, 32'h00000055);
    push("dual_rt_n_post", S_RT_N, 32'h00000055);
    check_all();

    // Reset beats HI/LO and GPR writes in the same cycle; bypass suppressed
    reset = 1'b1; hilo_we = 2'b11; hi_wdata = 32'h1; lo_wdata = 32'h2;
    wr_en = 1'b1; wr_addr = 5'd7; wr_byte_en = 4'b1111; wr_data = 32'hCAFEF00D;
    rs_addr = 5'd7; rt_addr = 5'd2; #1;
    push("rw_hi", S_HI, 32'h0); push("rw_lo", S_LO, 32'h0);
    push("rw_rs", S_RS, 32'h00000055); push("rw_rt", S_RT, 32'hDEADBEEF);
    check_all();
    tick();
    reset = 1'b0; wr_en = 1'b0; #1;
    push("rw_hi_byp", S_HI, 32'h1);  push("rw_lo_byp", S_LO, 32'h2);
    push("rw_hi_n",   S_HI_N, 32'h0); push("rw_lo_n",   S_LO_N, 32'h0);
    push("rw_rs_clr", S_RS, 32'h0);   push("rw_dbg_clr", S_DBG, 32'h0);
    check_all();
    tick(); idle(); #1;
    push("hilo_hi", S_HI, 32'h1);   push("hilo_lo", S_LO, 32'h2);
    push("hilo_hi_n", S_HI_N, 32'h1); push("hilo_lo_n", S_LO_N, 32'h2);
    check_all();

    // Randomised traffic against the model
    for (int it = 0; it < 300; it++) begin
      reset      = ($urandom_range(0, 39) == 0);
      wr_en      = 1'($urandom_range(0, 1));
      wr_addr    = 5'($urandom_range(0, 7));
      wr_byte_en = 4'($urandom);
      wr_data    = $urandom;
      rs_addr    = ($urandom_range(0, 1) == 0) ? wr_addr : 5'($urandom_range(0, 7));
      rt_addr    = 5'($urandom_range(0, 7));
      hilo_we    = 2'($urandom);
      hi_wdata   = $urandom;
      lo_wdata   = $urandom;
      #1;
      push_model("rnd");
      check_all();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
